// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC sequencer with IDLE/RUN/DONE control and PC_LUT branch redirects.
// Define PC_SEQ_STACK_EN to add a STACK_DEPTH-entry return-address stack for call/ret.
module pc_sequencer #(
  parameter int unsigned D           = 12,
  parameter int unsigned A           = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         jump,
  input  logic         call,
  input  logic         ret,
  input  logic [A-1:0] lut_idx,
  output logic [A-1:0] lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         stack_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [D-1:0] pc_nxt;
  logic [D-1:0] pc_inc;

  assign lut_addr = lut_idx;
  assign pc_inc   = prog_ctr + D'(1);

`ifdef PC_SEQ_STACK_EN
  localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;

  logic [D-1:0]   stack_mem [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_nxt;
  logic [SPW-2:0] top_idx;
  logic           push;
  logic           err_nxt;
  logic           stack_full;
  logic           stack_empty;

  // sp counts occupied entries, so it needs one bit beyond the index width.
  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = (SPW-1)'(sp - SPW'(1));
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
`ifdef PC_SEQ_STACK_EN
    sp_nxt    = sp;
    push      = 1'b0;
    err_nxt   = stack_err;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
`ifdef PC_SEQ_STACK_EN
          sp_nxt    = '0;
          err_nxt   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = DONE;
        end else if (stall) begin
          pc_nxt = prog_ctr;
`ifdef PC_SEQ_STACK_EN
        end else if (ret) begin
          if (stack_empty) begin
            pc_nxt  = pc_inc;
            err_nxt = 1'b1;
          end else begin
            pc_nxt = stack_mem[top_idx];
            sp_nxt = sp - SPW'(1);
          end
        end else if (call) begin
          pc_nxt = lut_target;
          if (stack_full) begin
            err_nxt = 1'b1;
          end else begin
            push   = 1'b1;
            sp_nxt = sp + SPW'(1);
          end
`endif
        end else if (jump || call) begin
          pc_nxt = lut_target;
        end else begin
          pc_nxt = pc_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      running  <= (state_nxt == RUN);
      done     <= (state_nxt == DONE);
    end
  end

`ifdef PC_SEQ_STACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      stack_err <= err_nxt;
    end
  end

  // Entries above sp are dead, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp[SPW-2:0]] <= pc_inc;
  end
`else
  localparam int unsigned unused_depth = STACK_DEPTH;
  logic unused_ret;
  assign unused_ret = ret;
  assign stack_err  = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the custom CPU fetch stage. Holds the architectural PC, controls start/halt/done, and redirects fetch through the `PC_LUT` branch-target table. It drives the table index and consumes the returned target. An optional return-address stack supports call/return.

## Interface
- `D`, 12, PC width; matches `PC_LUT` target width.
- `A`, 8, branch-table index width.
- `STACK_DEPTH`, 4, return-stack entries (power of two, ≥2); used only with the stack feature.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin execution at PC 0; sampled in IDLE and DONE.
- `stall`  in  1  hold PC this cycle.
- `halt`  in  1  decoded halt instruction.
- `jump`  in  1  taken branch; target from table.
- `call`  in  1  call; target from table, pushes return address.
- `ret`  in  1  return to popped address.
- `lut_idx`  in  A  branch-table index from the instruction.
- `lut_addr`  out  A  to `PC_LUT.addr`.
- `lut_target`  in  D  from `PC_LUT.target`.
- `prog_ctr`  out  D  registered PC, fetch address.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `stack_err`  out  1  sticky stack overflow/underflow flag.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on `halt`.
  - DONE → RUN on `start`.
  - `start` is ignored in RUN.
- Entering RUN loads `prog_ctr`=0, clears the stack pointer, and clears `stack_err`.
- Outside RUN, `prog_ctr` holds, and `stall`/`jump`/`call`/`ret`/`halt` are ignored.
- `lut_addr` = `lut_idx`, combinational in all states. `lut_target` must be combinational from `lut_addr`.
- RUN next-PC priority, highest first:
  1. `halt`: PC holds; go to DONE.
  2. `stall`: PC holds.
  3. `ret`: PC ← popped entry.
  4. `call`: push `prog_ctr`+1; PC ← `lut_target`.
  5. `jump`: PC ← `lut_target`.
  6. Otherwise: PC ← `prog_ctr`+1.
- PC arithmetic is modulo 2^D: 4095+1 → 0, and the pushed return address wraps the same way.
- A target of 0 is a legal jump to 0.
- Stack boundaries:
  - `call` when full: jump still taken, push dropped, `stack_err` set.
  - `ret` when empty: PC increments, `stack_err` set.
- `stack_err` stays set until reset or the next entry to RUN.

## Timing
- Reset values: `prog_ctr`=0, `running`=0, `done`=0, `stack_err`=0; state IDLE; stack pointer 0.
- Reset mid-RUN returns to IDLE at the next edge and discards stack contents.
- All redirects take effect at the next edge, with no bubble: the cycle after `jump` is sampled, `prog_ctr`=`lut_target`.
- `running` rises the cycle after `start` is sampled.
- `done` rises the cycle after `halt` is sampled and stays high until `start` is sampled in DONE.
- Outputs are registered, except `lut_addr`.

## Configuration
- Macro: `PC_SEQ_STACK_EN`.
- Defined: return stack of `STACK_DEPTH` entries and the full call/ret behaviour above.
- Undefined:
  - No stack storage.
  - `call` behaves exactly like `jump`.
  - `ret` is ignored, so PC increments unless a higher-priority input applies.
  - `stack_err` is tied to 0.

## Test plan
- Reset, then `start` for 1 cycle → `running`=1 next cycle. `prog_ctr` reads 0,1,2,3 on successive cycles; `done`=0.
- At PC 10, `jump` with `lut_idx`=2 and table returning 285 → next `prog_ctr`=285, then 286. Asserting `stall` with `jump` instead → PC holds 10.
- Macro on: at PC 20, `call` with a table target of 35 → PC 35; later `ret` → PC 21. Five nested calls with `STACK_DEPTH`=4 → `stack_err`=1; four rets return correctly.
- Macro on: `ret` with empty stack at PC 7 → PC 8, `stack_err`=1.
- Macro off: the same `call` → PC 35, and `ret` → PC 36.
- Free-run to PC 4095 → next PC 0.
- `halt` at PC 50 → `done`=1 next cycle and PC holds 50.
- `reset` mid-RUN → IDLE with `prog_ctr`=0 and all flags 0.
- `start` in DONE → PC 0, `running`=1.
